// File: rtl/mem_wb_pipe_if.sv
// MEM->WB bus: upstream entry handshake/fields and writeback handshake/fields.
// The pipeline stage uses the slave view; its environment uses the master view.
// Both handshakes: a transfer happens on a rising clk edge where valid and
// ready are both 1; valid may rise without waiting for ready, and an offered
// entry's fields must stay stable until the transfer completes.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Upstream (memory-access stage) side
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_whilo;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;
  logic              mem_llbit_we;
  logic              mem_llbit_value;

  // Downstream (register file / HI-LO writeback) side
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              wb_llbit_we;
  logic              wb_llbit_value;

  // Environment view: drives entries in and the writeback ready
  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo,
           mem_hi, mem_lo, mem_llbit_we, mem_llbit_value, wb_ready,
    input  mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo,
           wb_hi, wb_lo, wb_llbit_we, wb_llbit_value
  );

  // Pipeline-stage view
  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo,
           mem_hi, mem_lo, mem_llbit_we, mem_llbit_value, wb_ready,
    output mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo,
           wb_hi, wb_lo, wb_llbit_we, wb_llbit_value
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with a 2-entry skid buffer (main + skid), synchronous
// flush, HI/LO and LLbit write channels, r0 write squashing and a saturating
// count of back-pressured cycles.
module mem_wb_pipe #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int HILO_EN     = 1,
  parameter int R0_SUPPRESS = 1,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  mem_wb_pipe_if.slave        bus,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              llbit_we;
    logic              llbit_value;
  } entry_t;

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{wd:          bus.mem_wd,
                      wreg:        bus.mem_wreg,
                      wdata:       bus.mem_wdata,
                      whilo:       bus.mem_whilo,
                      hi:          bus.mem_hi,
                      lo:          bus.mem_lo,
                      llbit_we:    bus.mem_llbit_we,
                      llbit_value: bus.mem_llbit_value};

  // Ready depends only on registered state, so wb_ready never reaches mem_ready.
  assign bus.mem_ready = ~skid_valid_q;
  assign in_fire       = bus.mem_valid & bus.mem_ready;
  assign out_fire      = main_valid_q & bus.wb_ready;

  // Next state of main/skid; flush overrides every other event of the cycle.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire && skid_valid_q) begin
      // mem_ready is low while skid is full, so no input can arrive here.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (in_fire && (!main_valid_q || out_fire)) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end else if (in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  // Back-pressure counter: saturates, ignores flush, cleared only by reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !bus.wb_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers with asynchronous reset to an empty, all-zero stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Enables are qualified by valid; data fields show the stored entry as-is.
  assign bus.wb_valid       = main_valid_q;
  assign bus.wb_wd          = main_q.wd;
  assign bus.wb_wdata       = main_q.wdata;
  assign bus.wb_wreg        = main_q.wreg & main_valid_q &
                              ~((R0_SUPPRESS != 0) && (main_q.wd == '0));
  assign bus.wb_whilo       = main_q.whilo & main_valid_q & (HILO_EN != 0);
  assign bus.wb_hi          = main_q.hi & {DATA_W{HILO_EN != 0}};
  assign bus.wb_lo          = main_q.lo & {DATA_W{HILO_EN != 0}};
  assign bus.wb_llbit_we    = main_q.llbit_we & main_valid_q;
  assign bus.wb_llbit_value = main_q.llbit_value;
  assign stall_cnt          = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe. Instance a uses default parameters; instance
// b (HILO_EN=0, CNT_W=4) receives the same stimulus.
module tb_mem_wb_pipe;

  logic clk;
  logic rst;
  logic flush;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;
  int n_vec;
  int n_bad;

  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .HILO_EN(1), .R0_SUPPRESS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_a), .stall_cnt(stall_a)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .HILO_EN(0), .R0_SUPPRESS(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_b), .stall_cnt(stall_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one upstream entry (or idle) into both instances.
  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic whilo,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic llwe, input logic llv);
    bus_a.mem_valid = v;    bus_b.mem_valid = v;
    bus_a.mem_wd = wd;      bus_b.mem_wd = wd;
    bus_a.mem_wreg = wreg;  bus_b.mem_wreg = wreg;
    bus_a.mem_wdata = wdata; bus_b.mem_wdata = wdata;
    bus_a.mem_whilo = whilo; bus_b.mem_whilo = whilo;
    bus_a.mem_hi = hi;      bus_b.mem_hi = hi;
    bus_a.mem_lo = lo;      bus_b.mem_lo = lo;
    bus_a.mem_llbit_we = llwe; bus_b.mem_llbit_we = llwe;
    bus_a.mem_llbit_value = llv; bus_b.mem_llbit_value = llv;
  endtask

  task automatic send(input logic [4:0] wd, input logic [31:0] wdata);
    drive(1'b1, wd, 1'b1, wdata, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic set_ready(input logic r);
    bus_a.wb_ready = r;
    bus_b.wb_ready = r;
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    set_ready(1'b1);
    #12;

    // Reset state
    check("rst_wb_valid", bus_a.wb_valid, 0);
    check("rst_mem_ready", bus_a.mem_ready, 1);
    check("rst_wb_wd", bus_a.wb_wd, 0);
    check("rst_wb_wdata", bus_a.wb_wdata, 0);
    check("rst_stall", stall_a, 0);
    rst = 1'b0;

    // Streaming at full throughput
    send(5'd3, 32'h11); tick();
    check("str0_valid", bus_a.wb_valid, 1);
    check("str0_wd", bus_a.wb_wd, 3);
    check("str0_wdata", bus_a.wb_wdata, 32'h11);
    check("str0_wreg", bus_a.wb_wreg, 1);
    check("str0_ready", bus_a.mem_ready, 1);
    send(5'd4, 32'h22); tick();
    check("str1_wd", bus_a.wb_wd, 4);
    check("str1_wdata", bus_a.wb_wdata, 32'h22);
    check("str1_ready", bus_a.mem_ready, 1);
    send(5'd5, 32'h33); tick();
    check("str2_wd", bus_a.wb_wd, 5);
    check("str2_wdata", bus_a.wb_wdata, 32'h33);
    idle(); tick();
    check("str_drain_valid", bus_a.wb_valid, 0);

    // Back-pressure: A to main, B to skid, C waits for mem_ready
    set_ready(1'b0);
    send(5'd10, 32'hA); tick();
    check("bp_a_wdata", bus_a.wb_wdata, 32'hA);
    check("bp_a_ready", bus_a.mem_ready, 1);
    send(5'd11, 32'hB); tick();
    check("bp_b_ready", bus_a.mem_ready, 0);
    check("bp_b_main", bus_a.wb_wdata, 32'hA);
    send(5'd12, 32'hC); tick(); tick();
    check("bp_stall3", stall_a, 3);
    check("bp_hold_main", bus_a.wb_wdata, 32'hA);
    check("bp_hold_ready", bus_a.mem_ready, 0);
    set_ready(1'b1); tick();
    check("bp_out_b_wd", bus_a.wb_wd, 11);
    check("bp_out_b_data", bus_a.wb_wdata, 32'hB);
    check("bp_ready_back", bus_a.mem_ready, 1);
    tick();
    check("bp_out_c_wd", bus_a.wb_wd, 12);
    check("bp_out_c_data", bus_a.wb_wdata, 32'hC);
    check("bp_out_c_valid", bus_a.wb_valid, 1);
    idle(); tick();
    check("bp_drain_valid", bus_a.wb_valid, 0);
    check("bp_stall_kept", stall_a, 3);

    // Flush with main and skid full plus a concurrent input
    set_ready(1'b0);
    send(5'd13, 32'hD); tick();
    send(5'd14, 32'hE); tick();
    check("fl_pre_ready", bus_a.mem_ready, 0);
    flush = 1'b1;
    send(5'd7, 32'h77); tick();
    check("fl_valid", bus_a.wb_valid, 0);
    check("fl_ready", bus_a.mem_ready, 1);
    check("fl_stall", stall_a, 5);
    flush = 1'b0;
    idle(); set_ready(1'b1); tick();
    check("fl_after_valid", bus_a.wb_valid, 0);
    tick();
    check("fl_after2_valid", bus_a.wb_valid, 0);

    // r0 squash, HI/LO and LLbit channels
    drive(1'b1, 5'd0, 1'b1, 32'h55, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1); tick();
    check("r0_valid", bus_a.wb_valid, 1);
    check("r0_wreg", bus_a.wb_wreg, 0);
    check("r0_whilo", bus_a.wb_whilo, 1);
    check("r0_hi", bus_a.wb_hi, 32'hDEAD);
    check("r0_lo", bus_a.wb_lo, 32'hBEEF);
    check("r0_llwe", bus_a.wb_llbit_we, 1);
    check("r0_llv", bus_a.wb_llbit_value, 1);
    check("nohilo_whilo", bus_b.wb_whilo, 0);
    check("nohilo_hi", bus_b.wb_hi, 0);
    check("nohilo_lo", bus_b.wb_lo, 0);
    check("nohilo_wreg_r0", bus_b.wb_wreg, 0);
    drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    check("r9_wreg", bus_a.wb_wreg, 1);
    check("r9_whilo", bus_a.wb_whilo, 0);
    check("r9_llwe", bus_a.wb_llbit_we, 0);
    idle(); tick();
    check("inval_wreg", bus_a.wb_wreg, 0);
    check("inval_wdata_kept", bus_a.wb_wdata, 32'h99);

    // Asynchronous reset in the middle of traffic
    set_ready(1'b0);
    send(5'd6, 32'h66); tick();
    send(5'd8, 32'h88); tick();
    check("mid_pre_ready", bus_a.mem_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", bus_a.wb_valid, 0);
    check("mid_rst_ready", bus_a.mem_ready, 1);
    check("mid_rst_wd", bus_a.wb_wd, 0);
    check("mid_rst_wdata", bus_a.wb_wdata, 0);
    check("mid_rst_stall", stall_a, 0);
    idle();
    #3 rst = 1'b0;

    // Stall counter saturation: 20 stalled cycles
    send(5'd2, 32'h2); tick();
    idle();
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt16", stall_a, 20);
    check("sat_cnt4", stall_b, 15);
    check("sat_main_held", bus_a.wb_wdata, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
